// File: rtl/mips_ctrl_pkg.sv
// Shared types and constants for the multicycle MIPS controller.
//   state_t        : FSM state, encoding is what state_dbg shows
//   instr_class_t  : one bit per instruction class from the classifier
//   ctrl_t         : Moore part of the datapath control word
//   ctrl_decode()  : per-state Moore decode of ctrl_t
package mips_ctrl_pkg;

   typedef enum logic [3:0] {
      StFetch  = 4'd0,
      StDecode = 4'd1,
      StExecR  = 4'd2,
      StExecI  = 4'd3,
      StWbAlu  = 4'd4,
      StAddr   = 4'd5,
      StMem    = 4'd6,
      StWbMem  = 4'd7,
      StBranch = 4'd8,
      StJump   = 4'd9,
      StTrap   = 4'd10
   } state_t;

   // pc_src
   localparam logic [1:0] PcSrcSeq    = 2'd0;
   localparam logic [1:0] PcSrcBranch = 2'd1;
   localparam logic [1:0] PcSrcJump   = 2'd2;
   // alu_src_b
   localparam logic [1:0] AluBRt      = 2'd0;
   localparam logic [1:0] AluBFour    = 2'd1;
   localparam logic [1:0] AluBImm     = 2'd2;
   localparam logic [1:0] AluBImmSh   = 2'd3;
   // alu_op
   localparam logic [1:0] AluOpAdd    = 2'd0;
   localparam logic [1:0] AluOpCmp    = 2'd1;
   localparam logic [1:0] AluOpFunct  = 2'd2;
   localparam logic [1:0] AluOpOpcode = 2'd3;
   // reg_dst
   localparam logic [1:0] RegDstRt    = 2'd0;
   localparam logic [1:0] RegDstRd    = 2'd1;
   localparam logic [1:0] RegDstRa    = 2'd2;

   typedef struct packed {
      logic r;
      logic b1;
      logic j;
      logic b2;
      logic i;
      logic f;
      logic m;
   } instr_class_t;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       iord;
      logic       pc_we;
      logic       branch;
      logic [1:0] pc_src;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_we;
      logic [1:0] reg_dst;
      logic       mem_to_reg;
   } ctrl_t;

   // Moore outputs only; ir_we and the fetch-time pc_we are added by the caller.
   function automatic ctrl_t ctrl_decode(input state_t st, input logic [5:0] op,
                                         input logic is_r);
      ctrl_t c;
      c = '0;
      unique case (st)
         StFetch: begin
            c.mem_req   = 1'b1;
            c.pc_src    = PcSrcSeq;
            c.alu_src_b = AluBFour;
            c.alu_op    = AluOpAdd;
         end
         StDecode: begin
            c.alu_src_b = AluBImmSh;
            c.alu_op    = AluOpAdd;
         end
         StExecR: begin
            c.alu_src_b = AluBRt;
            c.alu_op    = AluOpFunct;
         end
         StExecI: begin
            c.alu_src_b = AluBImm;
            c.alu_op    = AluOpOpcode;
         end
         StWbAlu: begin
            c.reg_we  = 1'b1;
            c.reg_dst = is_r ? RegDstRd : RegDstRt;
         end
         StAddr: begin
            c.alu_src_b = AluBImm;
            c.alu_op    = AluOpAdd;
         end
         StMem: begin
            c.mem_req = 1'b1;
            c.iord    = 1'b1;
            c.mem_we  = op[3];  // 101xxx are stores
         end
         StWbMem: begin
            c.reg_we     = 1'b1;
            c.mem_to_reg = 1'b1;
            c.reg_dst    = RegDstRt;
         end
         StBranch: begin
            c.branch    = 1'b1;
            c.pc_src    = PcSrcBranch;
            c.alu_op    = AluOpCmp;
            c.alu_src_b = AluBRt;
         end
         StJump: begin
            c.pc_we  = 1'b1;
            c.pc_src = PcSrcJump;
            if (op[0]) begin  // jal links into r31
               c.reg_we  = 1'b1;
               c.reg_dst = RegDstRa;
            end
         end
         default: c = '0;
      endcase
      return c;
   endfunction

endpackage

// File: rtl/instruction_classifier.sv
// Classifies a MIPS primary opcode into instruction classes.
//   opcode_i : IR[31:26]
//   class_o  : class bits; all zero for opcodes outside every class
module instruction_classifier
   import mips_ctrl_pkg::*;
(
   input  logic [5:0]   opcode_i,
   output instr_class_t class_o
);

   always_comb begin
      class_o    = '0;
      class_o.r  = (opcode_i == 6'b000000);
      class_o.b1 = (opcode_i == 6'b000001);
      class_o.j  = (opcode_i[5:1] == 5'b00001);
      class_o.b2 = (opcode_i[5:2] == 4'b0001);
      class_o.i  = (opcode_i[5:3] == 3'b001);
      class_o.f  = (opcode_i[5:2] == 4'b0100);
      class_o.m  = (opcode_i[5:4] == 2'b10);
   end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Main sequencing FSM for the multicycle MIPS datapath.
//   clk, reset      : clock and asynchronous active-high reset
//   opcode          : IR[31:26], valid from DECODE on
//   mem_ready       : memory completes the pending request this cycle
//   mem_req/mem_we/iord          : memory request, store flag, address select
//   ir_we/pc_we/branch/pc_src    : IR and PC update controls
//   alu_src_b/alu_op             : ALU operand and operation selects
//   reg_we/reg_dst/mem_to_reg    : register file write-back controls
//   illegal/bus_err : sticky trap causes
//   state_dbg       : current state encoding
//   retired         : completed-instruction count (wraps)
module mips_multicycle_ctrl
   import mips_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W       = 32,
   parameter int unsigned MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [5:0]       opcode,
   input  logic             mem_ready,
   output logic             mem_req,
   output logic             mem_we,
   output logic             iord,
   output logic             ir_we,
   output logic             pc_we,
   output logic             branch,
   output logic [1:0]       pc_src,
   output logic [1:0]       alu_src_b,
   output logic [1:0]       alu_op,
   output logic             reg_we,
   output logic [1:0]       reg_dst,
   output logic             mem_to_reg,
   output logic             illegal,
   output logic             bus_err,
   output logic [3:0]       state_dbg,
   output logic [CNT_W-1:0] retired
);

   // Wait counter only needs to hold 0 .. MEM_TIMEOUT-1.
   localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

   state_t           state_q, state_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic [CNT_W-1:0] retired_q, retired_d;
   logic             illegal_q, illegal_d;
   logic             bus_err_q, bus_err_d;

   instr_class_t cls;
   ctrl_t        ctrl;
   logic         mem_done;
   logic         timeout;
   logic         retire;

   instruction_classifier u_classifier (
      .opcode_i (opcode),
      .class_o  (cls)
   );

   // Reset forces the decode to zero so an in-flight request drops in the same cycle.
   always_comb begin
      ctrl = '0;
      if (!reset) begin
         ctrl = ctrl_decode(state_q, opcode, cls.r);
      end
   end

   assign mem_done = ctrl.mem_req & mem_ready;
   assign timeout  = ctrl.mem_req & ~mem_ready & (wait_q == WaitW'(MEM_TIMEOUT - 1));

   always_comb begin
      state_d   = state_q;
      wait_d    = '0;
      retire    = 1'b0;
      illegal_d = illegal_q;
      bus_err_d = bus_err_q;
      unique case (state_q)
         StFetch: begin
            if (mem_done) begin
               state_d = StDecode;
            end else if (timeout) begin
               state_d   = StTrap;
               bus_err_d = 1'b1;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StDecode: begin
            if (cls.f) begin
               state_d   = StTrap;
               illegal_d = 1'b1;
            end else if (cls.r) begin
               state_d = StExecR;
            end else if (cls.i) begin
               state_d = StExecI;
            end else if (cls.m) begin
               state_d = StAddr;
            end else if (cls.b1 | cls.b2) begin
               state_d = StBranch;
            end else if (cls.j) begin
               state_d = StJump;
            end else begin
               state_d   = StTrap;
               illegal_d = 1'b1;
            end
         end
         StExecR, StExecI: state_d = StWbAlu;
         StAddr:           state_d = StMem;
         StMem: begin
            if (mem_done) begin
               if (opcode[3]) begin
                  retire  = 1'b1;
                  state_d = StFetch;
               end else begin
                  state_d = StWbMem;
               end
            end else if (timeout) begin
               state_d   = StTrap;
               bus_err_d = 1'b1;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StWbAlu, StWbMem, StBranch, StJump: begin
            retire  = 1'b1;
            state_d = StFetch;
         end
         StTrap:  state_d = StTrap;
         default: state_d = StFetch;
      endcase
      retired_d = retired_q + CNT_W'(retire);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= StFetch;
         wait_q    <= '0;
         retired_q <= '0;
         illegal_q <= 1'b0;
         bus_err_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         wait_q    <= wait_d;
         retired_q <= retired_d;
         illegal_q <= illegal_d;
         bus_err_q <= bus_err_d;
      end
   end

   assign mem_req    = ctrl.mem_req;
   assign mem_we     = ctrl.mem_we;
   assign iord       = ctrl.iord;
   assign ir_we      = (state_q == StFetch) & mem_done;
   assign pc_we      = ctrl.pc_we | ir_we;
   assign branch     = ctrl.branch;
   assign pc_src     = ctrl.pc_src;
   assign alu_src_b  = ctrl.alu_src_b;
   assign alu_op     = ctrl.alu_op;
   assign reg_we     = ctrl.reg_we;
   assign reg_dst    = ctrl.reg_dst;
   assign mem_to_reg = ctrl.mem_to_reg;
   assign illegal    = illegal_q;
   assign bus_err    = bus_err_q;
   assign state_dbg  = state_q;
   assign retired    = retired_q;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl with a per-cycle scoreboard.
module tb_mips_multicycle_ctrl;

   localparam int unsigned CNT_W       = 32;
   localparam int unsigned MEM_TIMEOUT = 15;

   localparam logic [3:0] SFetch  = 4'd0;
   localparam logic [3:0] SDecode = 4'd1;
   localparam logic [3:0] SExecR  = 4'd2;
   localparam logic [3:0] SExecI  = 4'd3;
   localparam logic [3:0] SWbAlu  = 4'd4;
   localparam logic [3:0] SAddr   = 4'd5;
   localparam logic [3:0] SMem    = 4'd6;
   localparam logic [3:0] SWbMem  = 4'd7;
   localparam logic [3:0] SBranch = 4'd8;
   localparam logic [3:0] SJump   = 4'd9;
   localparam logic [3:0] STrap   = 4'd10;

   localparam logic [5:0] OpR    = 6'b000000;
   localparam logic [5:0] OpAddi = 6'b001000;
   localparam logic [5:0] OpLw   = 6'b100011;
   localparam logic [5:0] OpSw   = 6'b101011;
   localparam logic [5:0] OpBeq  = 6'b000100;
   localparam logic [5:0] OpJal  = 6'b000011;
   localparam logic [5:0] OpJ    = 6'b000010;
   localparam logic [5:0] OpBltz = 6'b000001;
   localparam logic [5:0] OpFp   = 6'b010001;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic [5:0]       opcode = '0;
   logic             mem_ready = 1'b0;
   logic             mem_req, mem_we, iord, ir_we, pc_we, branch;
   logic [1:0]       pc_src, alu_src_b, alu_op, reg_dst;
   logic             reg_we, mem_to_reg, illegal, bus_err;
   logic [3:0]       state_dbg;
   logic [CNT_W-1:0] retired;

   mips_multicycle_ctrl #(
      .CNT_W       (CNT_W),
      .MEM_TIMEOUT (MEM_TIMEOUT)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .opcode     (opcode),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .iord       (iord),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .branch     (branch),
      .pc_src     (pc_src),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .reg_we     (reg_we),
      .reg_dst    (reg_dst),
      .mem_to_reg (mem_to_reg),
      .illegal    (illegal),
      .bus_err    (bus_err),
      .state_dbg  (state_dbg),
      .retired    (retired)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [53:0] vec;
   } exp_t;

   exp_t        sb[$];
   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_ret = '0;

   logic [15:0] c_zero, c_fw, c_fr, c_dec, c_exr, c_exi, c_wbr, c_wbi;
   logic [15:0] c_addr, c_mld, c_mst, c_wbm, c_br, c_jal, c_j;

   // {mem_req, mem_we, iord, ir_we, pc_we, branch, pc_src, alu_src_b, alu_op,
   //  reg_we, reg_dst, mem_to_reg}
   function automatic logic [15:0] mk(input logic mreq, input logic mwe, input logic io,
                                      input logic irwe, input logic pcwe, input logic br,
                                      input logic [1:0] psrc, input logic [1:0] asb,
                                      input logic [1:0] aop, input logic rwe,
                                      input logic [1:0] rdst, input logic m2r);
      return {mreq, mwe, io, irwe, pcwe, br, psrc, asb, aop, rwe, rdst, m2r};
   endfunction

   // One clock: drive inputs on the falling edge, sample 1 time unit later.
   task automatic step(input string tag, input logic rst, input logic rdy,
                       input logic [5:0] op, input logic [3:0] st, input logic [15:0] c,
                       input logic ill, input logic be);
      exp_t        e;
      logic [53:0] obs;
      @(negedge clk);
      reset     = rst;
      mem_ready = rdy;
      opcode    = op;
      e.tag = tag;
      e.vec = {st, c, ill, be, exp_ret};
      sb.push_back(e);
      #1;
      e   = sb.pop_front();
      obs = {state_dbg, mem_req, mem_we, iord, ir_we, pc_we, branch, pc_src, alu_src_b,
             alu_op, reg_we, reg_dst, mem_to_reg, illegal, bus_err, retired};
      checks++;
      assert (obs === e.vec)
      else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", e.tag, obs, e.vec);
      end
   endtask

   initial begin
      c_zero = '0;
      c_fw   = mk(1, 0, 0, 0, 0, 0, 2'd0, 2'd1, 2'd0, 0, 2'd0, 0);
      c_fr   = mk(1, 0, 0, 1, 1, 0, 2'd0, 2'd1, 2'd0, 0, 2'd0, 0);
      c_dec  = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd3, 2'd0, 0, 2'd0, 0);
      c_exr  = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd2, 0, 2'd0, 0);
      c_exi  = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd3, 0, 2'd0, 0);
      c_wbr  = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 2'd1, 0);
      c_wbi  = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 2'd0, 0);
      c_addr = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 0, 2'd0, 0);
      c_mld  = mk(1, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0);
      c_mst  = mk(1, 1, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 0, 2'd0, 0);
      c_wbm  = mk(0, 0, 0, 0, 0, 0, 2'd0, 2'd0, 2'd0, 1, 2'd0, 1);
      c_br   = mk(0, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd1, 0, 2'd0, 0);
      c_jal  = mk(0, 0, 0, 0, 1, 0, 2'd2, 2'd0, 2'd0, 1, 2'd2, 0);
      c_j    = mk(0, 0, 0, 0, 1, 0, 2'd2, 2'd0, 2'd0, 0, 2'd0, 0);

      #2 reset = 1'b1;

      // Reset held 3 cycles; mem_ready high in one of them must not raise ir_we.
      step("rst0", 1, 0, OpR, SFetch, c_zero, 0, 0);
      step("rst1", 1, 1, OpR, SFetch, c_zero, 0, 0);
      step("rst2", 1, 0, OpR, SFetch, c_zero, 0, 0);

      // R-type after two fetch wait cycles
      step("r_fw0", 0, 0, OpR, SFetch, c_fw, 0, 0);
      step("r_fw1", 0, 0, OpR, SFetch, c_fw, 0, 0);
      step("r_fr", 0, 1, OpR, SFetch, c_fr, 0, 0);
      step("r_dec", 0, 1, OpR, SDecode, c_dec, 0, 0);
      step("r_ex", 0, 1, OpR, SExecR, c_exr, 0, 0);
      step("r_wb", 0, 0, OpR, SWbAlu, c_wbr, 0, 0);
      exp_ret++;

      // addi, zero-wait
      step("i_fr", 0, 1, OpAddi, SFetch, c_fr, 0, 0);
      step("i_dec", 0, 0, OpAddi, SDecode, c_dec, 0, 0);
      step("i_ex", 0, 0, OpAddi, SExecI, c_exi, 0, 0);
      step("i_wb", 0, 0, OpAddi, SWbAlu, c_wbi, 0, 0);
      exp_ret++;

      // lw with two memory wait cycles
      step("lw_fr", 0, 1, OpLw, SFetch, c_fr, 0, 0);
      step("lw_dec", 0, 0, OpLw, SDecode, c_dec, 0, 0);
      step("lw_addr", 0, 0, OpLw, SAddr, c_addr, 0, 0);
      step("lw_mw0", 0, 0, OpLw, SMem, c_mld, 0, 0);
      step("lw_mw1", 0, 0, OpLw, SMem, c_mld, 0, 0);
      step("lw_mr", 0, 1, OpLw, SMem, c_mld, 0, 0);
      step("lw_wb", 0, 0, OpLw, SWbMem, c_wbm, 0, 0);
      exp_ret++;

      // sw retires straight out of MEM
      step("sw_fr", 0, 1, OpSw, SFetch, c_fr, 0, 0);
      step("sw_dec", 0, 0, OpSw, SDecode, c_dec, 0, 0);
      step("sw_addr", 0, 0, OpSw, SAddr, c_addr, 0, 0);
      step("sw_mr", 0, 1, OpSw, SMem, c_mst, 0, 0);
      exp_ret++;

      step("beq_fr", 0, 1, OpBeq, SFetch, c_fr, 0, 0);
      step("beq_dec", 0, 0, OpBeq, SDecode, c_dec, 0, 0);
      step("beq_br", 0, 0, OpBeq, SBranch, c_br, 0, 0);
      exp_ret++;

      step("jal_fr", 0, 1, OpJal, SFetch, c_fr, 0, 0);
      step("jal_dec", 0, 0, OpJal, SDecode, c_dec, 0, 0);
      step("jal_jp", 0, 0, OpJal, SJump, c_jal, 0, 0);
      exp_ret++;

      step("j_fr", 0, 1, OpJ, SFetch, c_fr, 0, 0);
      step("j_dec", 0, 0, OpJ, SDecode, c_dec, 0, 0);
      step("j_jp", 0, 0, OpJ, SJump, c_j, 0, 0);
      exp_ret++;

      step("bltz_fr", 0, 1, OpBltz, SFetch, c_fr, 0, 0);
      step("bltz_dec", 0, 0, OpBltz, SDecode, c_dec, 0, 0);
      step("bltz_br", 0, 0, OpBltz, SBranch, c_br, 0, 0);
      exp_ret++;

      // Ready on the timeout cycle: completion wins
      step("lwc_fr", 0, 1, OpLw, SFetch, c_fr, 0, 0);
      step("lwc_dec", 0, 0, OpLw, SDecode, c_dec, 0, 0);
      step("lwc_addr", 0, 0, OpLw, SAddr, c_addr, 0, 0);
      for (int k = 0; k < MEM_TIMEOUT - 1; k++) begin
         step("lwc_mw", 0, 0, OpLw, SMem, c_mld, 0, 0);
      end
      step("lwc_mr", 0, 1, OpLw, SMem, c_mld, 0, 0);
      step("lwc_wb", 0, 0, OpLw, SWbMem, c_wbm, 0, 0);
      exp_ret++;

      // Memory never answers: bus error after MEM_TIMEOUT wait cycles
      step("to_fr", 0, 1, OpLw, SFetch, c_fr, 0, 0);
      step("to_dec", 0, 0, OpLw, SDecode, c_dec, 0, 0);
      step("to_addr", 0, 0, OpLw, SAddr, c_addr, 0, 0);
      for (int k = 0; k < MEM_TIMEOUT; k++) begin
         step("to_mw", 0, 0, OpLw, SMem, c_mld, 0, 0);
      end
      for (int k = 0; k < 3; k++) begin
         step("to_trap", 0, 1, OpLw, STrap, c_zero, 0, 1);
      end

      // Reset clears sticky flags and the counter
      exp_ret = '0;
      step("rst_be", 1, 0, OpFp, SFetch, c_zero, 0, 0);

      // FP opcode traps as illegal and stays there
      step("fp_fr", 0, 1, OpFp, SFetch, c_fr, 0, 0);
      step("fp_dec", 0, 0, OpFp, SDecode, c_dec, 0, 0);
      for (int k = 0; k < 20; k++) begin
         step("fp_trap", 0, 1'(k), OpFp, STrap, c_zero, 1, 0);
      end
      step("rst_fp", 1, 0, OpBeq, SFetch, c_zero, 0, 0);

      // Retire one, then reset in the middle of a store request
      step("b2_fr", 0, 1, OpBeq, SFetch, c_fr, 0, 0);
      step("b2_dec", 0, 0, OpBeq, SDecode, c_dec, 0, 0);
      step("b2_br", 0, 0, OpBeq, SBranch, c_br, 0, 0);
      exp_ret++;
      step("sw2_fr", 0, 1, OpSw, SFetch, c_fr, 0, 0);
      step("sw2_dec", 0, 0, OpSw, SDecode, c_dec, 0, 0);
      step("sw2_addr", 0, 0, OpSw, SAddr, c_addr, 0, 0);
      step("sw2_mw", 0, 0, OpSw, SMem, c_mst, 0, 0);
      exp_ret = '0;
      step("sw2_rst", 1, 1, OpSw, SFetch, c_zero, 0, 0);
      step("post_rst", 0, 0, OpSw, SFetch, c_fw, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
